piso_shifter: RTL and testbench
===============================

PISO_SHIFTER -- requirements
Module: piso_shifter

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..64.
REQ-002 Parameter LSB_FIRST, default 1: 1 = bit 0 serialized first, 0 = bit WIDTH-1 first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  in_data holds a word to serialize.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  WIDTH  parallel word.
REQ-008 out_valid  output  1  out_bit holds a valid serial bit.
REQ-009 out_ready  input  1  downstream consumes out_bit this cycle.
REQ-010 out_bit  output  1  current serial bit.
REQ-011 out_last  output  1  out_bit is the final bit of the current word.

Function
REQ-012 Word accept: in_valid && in_ready at a rising edge; bit transfer: out_valid && out_ready at a rising edge.
REQ-013 Two states: IDLE (no word held) and SHIFT (word held, bits pending).
REQ-014 IDLE: in_ready=1, out_valid=0; word accept -> load shift register with in_data, load bit counter with WIDTH-1, go to SHIFT.
REQ-015 SHIFT: out_valid=1; out_bit = shift register bit 0 (LSB_FIRST=1) or bit WIDTH-1 (LSB_FIRST=0).
REQ-016 SHIFT, bit transfer with counter > 0: shift register moves one position toward the output end, counter decrements by 1, state stays SHIFT.
REQ-017 out_last = 1 exactly when state is SHIFT and counter == 0.
REQ-018 in_ready = 1 in IDLE, or in SHIFT when out_last && out_ready; 0 otherwise (combinational from state, counter, out_ready).
REQ-019 Last-bit transfer with no word accept in the same cycle: go to IDLE.
REQ-020 Last-bit transfer with a word accept in the same cycle: load the new word, counter = WIDTH-1, stay in SHIFT; no idle cycle between words.
REQ-021 SHIFT with out_ready=0: out_bit, out_last, counter and shift register hold; in_data changes are ignored.
REQ-022 Downstream backpressure SHALL NOT drop, duplicate or reorder bits; every accepted word produces exactly WIDTH transfers, with out_last on the last one.
REQ-023 Throughput: one bit per cycle when out_ready is held 1; latency from word accept to first valid bit = 1 cycle.
REQ-024 Counter width = $clog2(WIDTH); counter never decrements below 0 and never wraps.
REQ-025 in_valid in SHIFT while in_ready=0 has no effect; upstream holds the word until accepted.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, counter 0, shift register 0, out_valid 0, out_bit 0, out_last 0, in_ready 1.
REQ-027 Reset asserted mid-word discards the remaining bits; after release the next transfer belongs to a newly accepted word.
REQ-028 Reset release is synchronous to clk; first word accept is possible on the first rising edge after rst_n goes to 1.
REQ-029 No state or output SHALL be X after reset, independent of the state before reset.

Verification
REQ-030 WIDTH=8, LSB_FIRST=1, out_ready=1, accept 0xA5 -> out_bit sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; out_last on the 8th only; then out_valid=0.
REQ-031 LSB_FIRST=0, accept 0xA5 -> sequence 1,0,1,0,0,1,0,1 (MSB first); accept 0x01 -> seven 0s then 1 with out_last.
REQ-032 Back-to-back: in_valid held with 0xFF then 0x00, out_ready=1 -> 16 consecutive transfers (eight 1s, eight 0s), out_valid never drops, out_last on transfers 8 and 16.
REQ-033 Backpressure: 0x3C with out_ready toggled randomly -> transfers still give bits 0,0,1,1,1,1,0,0; out_bit and out_last stable while out_ready=0; in_ready=0 until the last-bit transfer.
REQ-034 Reset mid-word: accept 0xF0, transfer 3 bits, pulse rst_n low between edges -> out_valid=0, in_ready=1 at once; then accept 0x0F -> 1,1,1,1,0,0,0,0 with no leftover bits.
REQ-035 In SHIFT, in_valid=1 with in_data changing each cycle and out_ready=0 -> no word accepted, out_bit unchanged.

Source files
------------

// File: rtl/piso_shifter.sv
// Parallel-in / serial-out shifter with valid/ready handshakes on both sides.
// A word is accepted in IDLE, or on the cycle that its predecessor's last bit
// leaves, so back-to-back words stream with no bubble between them.
module piso_shifter #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;

  // Shift register advanced one position toward the output end.
  assign shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  // The serial bit is taken straight from the output end of the register.
  assign out_bit = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

  // A new word can enter in IDLE or while the last bit is being consumed.
  assign in_ready = (state == IDLE) || (out_last && out_ready);

  // Handshake FSM: loads words, shifts on each bit transfer, chains words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= SHIFT;
            shreg     <= in_data;
            cnt       <= CNT_LOAD;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (cnt != '0) begin
              shreg    <= shreg_next;
              cnt      <= cnt - CNT_ONE;
              out_last <= (cnt == CNT_ONE);
            end else if (in_valid) begin
              shreg    <= in_data;
              cnt      <= CNT_LOAD;
              out_last <= 1'b0;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shifter.sv
// Self-checking bench for piso_shifter. Two instances (LSB-first and
// MSB-first) share the same stimulus; each is compared against a queue of
// expected serial bits built from every accepted word.
module tb_piso_shifter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic in_ready_l, out_valid_l, out_bit_l, out_last_l;
  logic in_ready_m, out_valid_m, out_bit_m, out_last_m;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic b;
    logic last;
  } sbit_t;

  sbit_t        q_l[$];
  sbit_t        q_m[$];
  logic [W-1:0] src[$];
  logic [W-1:0] cap_l = '0;
  logic [W-1:0] cap_m = '0;

  always #5 clk = ~clk;

  piso_shifter #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready),
    .out_bit(out_bit_l), .out_last(out_last_l)
  );

  piso_shifter #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data),
    .out_valid(out_valid_m), .out_ready(out_ready),
    .out_bit(out_bit_m), .out_last(out_last_m)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected serial stream of one word, in the order each instance emits it.
  task automatic push_word(input logic [W-1:0] d);
    sbit_t e;
    for (int i = 0; i < W; i++) begin
      e.last = (i == W - 1);
      e.b = d[i];
      q_l.push_back(e);
      e.b = d[W-1-i];
      q_m.push_back(e);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model.
  task automatic cycle(output bit acc);
    bit exp_rdy;
    sbit_t f;
    @(negedge clk);
    exp_rdy = (q_l.size() == 0) || (q_l.size() == 1 && out_ready);
    check("in_ready_lsb", in_ready_l, exp_rdy);
    check("in_ready_msb", in_ready_m, exp_rdy);
    check("out_valid_lsb", out_valid_l, q_l.size() != 0);
    check("out_valid_msb", out_valid_m, q_m.size() != 0);
    if (q_l.size() != 0) begin
      f = q_l[0];
      check("out_bit_lsb", out_bit_l, f.b);
      check("out_last_lsb", out_last_l, f.last);
    end else begin
      check("out_last_lsb_idle", out_last_l, 1'b0);
    end
    if (q_m.size() != 0) begin
      f = q_m[0];
      check("out_bit_msb", out_bit_m, f.b);
      check("out_last_msb", out_last_m, f.last);
    end else begin
      check("out_last_msb_idle", out_last_m, 1'b0);
    end
    if (q_l.size() != 0 && out_ready) begin
      cap_l = {out_bit_l, cap_l[W-1:1]};
      cap_m = {cap_m[W-2:0], out_bit_m};
      void'(q_l.pop_front());
      void'(q_m.pop_front());
    end
    acc = in_valid && exp_rdy;
    if (acc) push_word(in_data);
    @(posedge clk);
    #1;
  endtask

  // Present words from src as soon as they are accepted.
  task automatic run(input int ncyc, input bit rand_ready);
    bit acc;
    for (int c = 0; c < ncyc; c++) begin
      in_valid  = (src.size() != 0);
      in_data   = (src.size() != 0) ? src[0] : W'($urandom);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(acc);
      if (acc) void'(src.pop_front());
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_lsb"}, out_valid_l, 1'b0);
    check({tag, "_valid_msb"}, out_valid_m, 1'b0);
    check({tag, "_ready_lsb"}, in_ready_l, 1'b1);
    check({tag, "_ready_msb"}, in_ready_m, 1'b1);
    check({tag, "_bit_lsb"}, out_bit_l, 1'b0);
    check({tag, "_bit_msb"}, out_bit_m, 1'b0);
    check({tag, "_last_lsb"}, out_last_l, 1'b0);
    check({tag, "_last_msb"}, out_last_m, 1'b0);
  endtask

  initial begin
    bit acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word 0xA5 with free-running output; then idle.
    src.push_back(8'hA5);
    run(11, 1'b0);
    check("a5_seq_lsb", cap_l, 8'hA5);
    check("a5_seq_msb", cap_m, 8'hA5);

    // 0x01: MSB-first gives seven zeros then a one with out_last.
    src.push_back(8'h01);
    run(11, 1'b0);
    check("01_seq_lsb", cap_l, 8'h01);
    check("01_seq_msb", cap_m, 8'h01);

    // Back-to-back 0xFF, 0x00: no gap between words.
    src.push_back(8'hFF);
    src.push_back(8'h00);
    run(19, 1'b0);

    // 0x3C under random backpressure.
    src.push_back(8'h3C);
    run(40, 1'b1);
    run(10, 1'b0);
    check("3c_seq_lsb", cap_l, 8'h3C);
    check("3c_seq_msb", cap_m, 8'h3C);

    // Stalled word with in_data changing every cycle: nothing accepted.
    src.push_back(8'h96);
    run(1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      out_ready = 1'b0;
      cycle(acc);
    end
    in_valid = 1'b0;
    run(12, 1'b0);
    check("stall_seq_lsb", cap_l, 8'h96);
    check("stall_seq_msb", cap_m, 8'h96);

    // Reset mid-word: 0xF0, three bits out, then an asynchronous pulse.
    src.push_back(8'hF0);
    run(4, 1'b0);
    rst_n = 1'b0;
    #1;
    q_l.delete();
    q_m.delete();
    check_reset_outputs("midrst");
    #1;
    rst_n = 1'b1;
    src.push_back(8'h0F);
    run(11, 1'b0);
    check("0f_seq_lsb", cap_l, 8'h0F);
    check("0f_seq_msb", cap_m, 8'h0F);

    // Random words, random source gaps and random backpressure.
    for (int w = 0; w < 40; w++) begin
      src.push_back(W'($urandom));
      run($urandom_range(1, 12), 1'b1);
    end
    run(400, 1'b1);
    run(20, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
